// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between fetch (I) and load/store (D).
// Latency: read done 3 cycles after grant sample, write done 2 cycles; +1 per waitrequest cycle.
// Backpressure: waitrequest freezes address/data/byteenable/strobe; requesters hold req until done.
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        reset,

    // Instruction-fetch requester
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,

    // Load/store requester
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteenable,
    output logic        d_done,
    output logic [31:0] d_rdata,

    // Avalon-MM master
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,

    output logic        busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_I_BUS  = 3'd1;
    localparam logic [2:0] ST_I_RESP = 3'd2;
    localparam logic [2:0] ST_D_BUS  = 3'd3;
    localparam logic [2:0] ST_D_RESP = 3'd4;

    // Encoding of the port that received the most recent grant.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic [2:0] state;
    logic [2:0] next_state;
    logic       last_grant;
    logic       d_is_write;   // kind of the D transaction captured at grant

    logic       i_eligible;
    logic       d_eligible;
    logic       grant_i;
    logic       grant_d;

    // A port completing this cycle still has req high; mask it so it is not
    // immediately re-granted and the other port gets the bus first.
    assign i_eligible = i_req & ~i_done;
    assign d_eligible = d_req & ~d_done;

    // Tie-break favours the port that was not served last.
    assign grant_i = (state == ST_IDLE) && i_eligible &&
                     (!d_eligible || (last_grant == GRANT_D));
    assign grant_d = (state == ST_IDLE) && d_eligible &&
                     (!i_eligible || (last_grant == GRANT_I));

    assign busy = (state != ST_IDLE);

    // Next-state decode for the single-transaction sequencer.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (grant_i) begin
                    next_state = ST_I_BUS;
                end else if (grant_d) begin
                    next_state = ST_D_BUS;
                end
            end
            ST_I_BUS: begin
                if (!waitrequest) begin
                    next_state = ST_I_RESP;
                end
            end
            ST_I_RESP: begin
                next_state = ST_IDLE;
            end
            ST_D_BUS: begin
                if (!waitrequest) begin
                    // Stores complete on acceptance; loads wait for readdata.
                    next_state = d_is_write ? ST_IDLE : ST_D_RESP;
                end
            end
            ST_D_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Round-robin history and transaction-kind latch, both updated on grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GRANT_D;
            d_is_write <= 1'b0;
        end else if (grant_i) begin
            last_grant <= GRANT_I;
        end else if (grant_d) begin
            last_grant <= GRANT_D;
            d_is_write <= d_write;
        end
    end

    // Avalon address/data/byteenable: captured from the winning requester at
    // grant and held unchanged until the next grant, so stalls see stable fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            address    <= 32'd0;
            writedata  <= 32'd0;
            byteenable <= 4'd0;
        end else if (grant_i) begin
            address    <= i_addr;
            byteenable <= 4'b1111;
        end else if (grant_d) begin
            address    <= d_addr;
            writedata  <= d_wdata;
            byteenable <= d_byteenable;
        end
    end

    // Avalon strobes: raised on grant, dropped once the slave accepts.
    // read and write are set mutually exclusively from the same grant decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            read  <= 1'b0;
            write <= 1'b0;
        end else begin
            if (grant_i) begin
                read  <= 1'b1;
                write <= 1'b0;
            end else if (grant_d) begin
                read  <= ~d_write;
                write <= d_write;
            end else if (((state == ST_I_BUS) || (state == ST_D_BUS)) && !waitrequest) begin
                read  <= 1'b0;
                write <= 1'b0;
            end
        end
    end

    // Completion pulses and read-data capture; rdata holds between completions.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            i_rdata <= 32'd0;
            d_rdata <= 32'd0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                ST_I_RESP: begin
                    i_rdata <= readdata;
                    i_done  <= 1'b1;
                end
                ST_D_RESP: begin
                    d_rdata <= readdata;
                    d_done  <= 1'b1;
                end
                ST_D_BUS: begin
                    if (!waitrequest && d_is_write) begin
                        d_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with hand-computed expectations.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Every comparison goes through check(); a summary line closes the run.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteenable;
    logic        d_done;
    logic [31:0] d_rdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_done       (i_done),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_byteenable (d_byteenable),
        .d_done       (d_done),
        .d_rdata      (d_rdata),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] alt_exp [4];
    int          n_grants;
    logic        prev_strobe;

    initial begin
        reset        = 1'b1;
        i_req        = 1'b0;
        i_addr       = 32'd0;
        d_req        = 1'b0;
        d_write      = 1'b0;
        d_addr       = 32'd0;
        d_wdata      = 32'd0;
        d_byteenable = 4'd0;
        waitrequest  = 1'b0;
        readdata     = 32'hFFFF_FFFF;
        tick();
        tick();

        // ---- reset state ----
        check("rst_read",  read,       0);
        check("rst_write", write,      0);
        check("rst_addr",  address,    0);
        check("rst_wdata", writedata,  0);
        check("rst_be",    byteenable, 0);
        check("rst_idone", i_done,     0);
        check("rst_ddone", d_done,     0);
        check("rst_irdat", i_rdata,    0);
        check("rst_drdat", d_rdata,    0);
        check("rst_busy",  busy,       0);
        reset = 1'b0;
        tick();

        // ---- single zero-wait fetch ----
        i_req  = 1'b1;
        i_addr = 32'hBFC0_0000;
        check("f_k_read", read, 0);
        tick();                                   // k+1
        check("f_k1_read", read, 1);
        check("f_k1_write", write, 0);
        check("f_k1_addr", address, 32'hBFC0_0000);
        check("f_k1_be", byteenable, 4'b1111);
        check("f_k1_busy", busy, 1);
        tick();                                   // k+2
        readdata = 32'h2402_0005;
        check("f_k2_read", read, 0);
        check("f_k2_idone", i_done, 0);
        tick();                                   // k+3
        readdata = 32'h1111_1111;
        check("f_k3_idone", i_done, 1);
        check("f_k3_irdat", i_rdata, 32'h2402_0005);
        check("f_k3_busy", busy, 0);
        i_req = 1'b0;
        tick();
        check("f_k4_idone", i_done, 0);
        check("f_k4_irdat_hold", i_rdata, 32'h2402_0005);
        check("f_k4_read", read, 0);

        // ---- store with three stall cycles ----
        d_req        = 1'b1;
        d_write      = 1'b1;
        d_addr       = 32'h0000_1000;
        d_wdata      = 32'hDEAD_BEEF;
        d_byteenable = 4'b0011;
        waitrequest  = 1'b1;
        tick();                                   // k+1
        d_addr  = 32'h5555_5555;                  // ignored after grant
        d_wdata = 32'h5555_5555;
        for (int i = 0; i < 4; i++) begin
            check("st_write", write, 1);
            check("st_read", read, 0);
            check("st_addr", address, 32'h0000_1000);
            check("st_wdata", writedata, 32'hDEAD_BEEF);
            check("st_be", byteenable, 4'b0011);
            check("st_ddone_early", d_done, 0);
            if (i == 3) waitrequest = 1'b0;
            tick();
        end
        check("st_ddone", d_done, 1);
        check("st_write_off", write, 0);
        d_req = 1'b0;
        tick();
        check("st_ddone_once", d_done, 0);

        // ---- continuous tie: grants alternate I, D, I, D ----
        alt_exp[0] = 32'h0000_0100;
        alt_exp[1] = 32'h0000_0200;
        alt_exp[2] = 32'h0000_0100;
        alt_exp[3] = 32'h0000_0200;
        i_addr       = 32'h0000_0100;
        d_addr       = 32'h0000_0200;
        d_write      = 1'b1;
        d_wdata      = 32'h0BAD_F00D;
        d_byteenable = 4'b1111;
        readdata     = 32'h7777_7777;
        i_req        = 1'b1;
        d_req        = 1'b1;
        n_grants     = 0;
        prev_strobe  = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            check("alt_rw_excl", {31'd0, read & write}, 0);
            if ((read || write) && !prev_strobe && n_grants < 4) begin
                check("alt_addr", address, alt_exp[n_grants]);
                n_grants++;
            end
            prev_strobe = read | write;
        end
        check("alt_count", n_grants, 4);
        i_req = 1'b0;
        d_req = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        check("alt_drained", busy, 0);

        // ---- back-to-back: D load, I queued behind it ----
        d_req        = 1'b1;
        d_write      = 1'b0;
        d_addr       = 32'h0000_0300;
        d_byteenable = 4'b0101;
        tick();                                   // k+1
        check("bb_d_read", read, 1);
        check("bb_d_addr", address, 32'h0000_0300);
        check("bb_d_be", byteenable, 4'b0101);
        i_req  = 1'b1;
        i_addr = 32'h0000_0400;
        tick();                                   // k+2 D_RESP
        readdata = 32'hCAFE_F00D;
        check("bb_d_resp_read", read, 0);
        tick();                                   // k+3 d_done
        readdata = 32'h1111_1111;
        check("bb_ddone", d_done, 1);
        check("bb_drdat", d_rdata, 32'hCAFE_F00D);
        check("bb_done_read", read, 0);
        d_req = 1'b0;
        tick();                                   // k+4 I_BUS
        check("bb_i_read", read, 1);
        check("bb_i_addr", address, 32'h0000_0400);
        check("bb_i_be", byteenable, 4'b1111);
        check("bb_drdat_hold1", d_rdata, 32'hCAFE_F00D);
        tick();                                   // k+5 I_RESP
        readdata = 32'hABCD_0123;
        check("bb_drdat_hold2", d_rdata, 32'hCAFE_F00D);
        tick();                                   // k+6 i_done
        check("bb_idone", i_done, 1);
        check("bb_irdat", i_rdata, 32'hABCD_0123);
        check("bb_drdat_hold3", d_rdata, 32'hCAFE_F00D);
        check("bb_ddone_quiet", d_done, 0);
        i_req = 1'b0;
        tick();

        // ---- reset during a stalled fetch ----
        i_req       = 1'b1;
        i_addr      = 32'h0000_0500;
        waitrequest = 1'b1;
        tick();
        check("rs_read_pre", read, 1);
        tick();
        check("rs_read_stall", read, 1);
        reset = 1'b1;
        i_req = 1'b0;
        tick();
        check("rs_read", read, 0);
        check("rs_write", write, 0);
        check("rs_busy", busy, 0);
        check("rs_idone", i_done, 0);
        reset       = 1'b0;
        waitrequest = 1'b0;
        i_req       = 1'b1;
        d_req       = 1'b1;
        d_write     = 1'b1;
        d_addr      = 32'h0000_0600;
        tick();
        check("rs_tie_read", read, 1);
        check("rs_tie_write", write, 0);
        check("rs_tie_addr", address, 32'h0000_0500);
        check("rs_idone2", i_done, 0);
        i_req = 1'b0;
        d_req = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        check("rs_drained", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
